// File: rtl/des_key_sched.sv
// DES/3DES round-key schedule walker: rotates C||D once per accepted round key.
// Define DES_KS_PC2_EN to add a PC-2 compressed subkey output (requires W=28).
module des_key_sched #(
    parameter int              W           = 28,
    parameter int              NR          = 16,
    parameter logic [NR-1:0]   SHIFT1_MASK = 16'h8103,
    localparam int             RW          = $clog2(NR + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*W-1:0]  key_in,
    input  logic            decrypt,
    input  logic            abort,
    output logic            busy,
    output logic            sub_valid,
    input  logic            sub_ready,
    output logic [2*W-1:0]  sub_cd,
    output logic [RW-1:0]   round,
`ifdef DES_KS_PC2_EN
    output logic [47:0]     subkey,
`endif
    output logic            done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [2*W-1:0]  cd;
    logic            mode;

    // True when round r uses a two-bit rotation.
    function automatic logic two_of(input int r);
        logic t;
        t = 1'b0;
        for (int k = 0; k < NR; k++)
            if (k == r - 1) t = !SHIFT1_MASK[k];
        return t;
    endfunction

    function automatic logic [W-1:0] rot_half(input logic [W-1:0] x,
                                              input logic two,
                                              input logic left);
        logic [2*W-1:0] d;
        logic [W-1:0]   y;
        d = {x, x};
        unique case ({left, two})
            2'b10:   y = d[2*W-2 -: W];
            2'b11:   y = d[2*W-3 -: W];
            2'b00:   y = d[W -: W];
            default: y = d[W+1 -: W];
        endcase
        return y;
    endfunction

    function automatic logic [2*W-1:0] rot_cd(input logic [2*W-1:0] v,
                                              input logic two,
                                              input logic left);
        return {rot_half(v[2*W-1:W], two, left), rot_half(v[W-1:0], two, left)};
    endfunction

    assign busy      = (state == RUN);
    assign sub_valid = (state == RUN);
    assign sub_cd    = cd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cd    <= '0;
            round <= '0;
            mode  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                round <= '0;
            end else begin
                unique case (state)
                    IDLE: if (start) begin
                        mode  <= decrypt;
                        round <= RW'(1);
                        state <= RUN;
                        cd    <= decrypt ? key_in : rot_cd(key_in, two_of(1), 1'b1);
                    end
                    RUN: if (sub_ready) begin
                        if (round == RW'(NR)) begin
                            state <= IDLE;
                            round <= '0;
                            done  <= 1'b1;
                        end else begin
                            round <= round + RW'(1);
                            // Decrypt replays the encrypt shifts backwards, undoing each.
                            cd <= mode
                                ? rot_cd(cd, two_of(NR + 1 - int'(round)), 1'b0)
                                : rot_cd(cd, two_of(int'(round) + 1), 1'b1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DES_KS_PC2_EN
    if (W != 28) begin : g_bad_w
        $error("des_key_sched: PC-2 output needs W=28");
    end

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    always_comb begin
        subkey = '0;
        if (state == RUN)
            for (int j = 0; j < 48; j++)
                subkey[47-j] = cd[56-PC2[j]];
    end
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: vector table, random runs vs a cumulative-shift model,
// stall/abort/poke/async-reset sequences and a small W=8 NR=4 configuration.
module tb_des_key_sched;

    logic        clk;
    logic        rst_n;
    logic        start, decrypt, abort, sub_ready;
    logic [55:0] key_in;
    logic        busy, sub_valid, done;
    logic [55:0] sub_cd;
    logic [4:0]  round;
`ifdef DES_KS_PC2_EN
    logic [47:0] subkey;
`endif

    logic        m_start, m_decrypt, m_abort, m_ready;
    logic [15:0] m_key;
    logic        m_busy, m_valid, m_done;
    logic [15:0] m_cd;
    logic [2:0]  m_round;

    int tests = 0;
    int fails = 0;

    des_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .decrypt(decrypt), .abort(abort), .busy(busy),
        .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_cd(sub_cd),
        .round(round),
`ifdef DES_KS_PC2_EN
        .subkey(subkey),
`endif
        .done(done)
    );

`ifndef DES_KS_PC2_EN
    des_key_sched #(.W(8), .NR(4), .SHIFT1_MASK(4'b0001)) mini (
        .clk(clk), .rst_n(rst_n), .start(m_start), .key_in(m_key),
        .decrypt(m_decrypt), .abort(m_abort), .busy(m_busy),
        .sub_valid(m_valid), .sub_ready(m_ready), .sub_cd(m_cd),
        .round(m_round), .done(m_done)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-r C||D from the net rotation accumulated by the schedule.
    function automatic logic [63:0] model(input logic [63:0] key, input logic dec,
                                          input int r, input int w, input int nr,
                                          input logic [31:0] mask);
        int sum, amt;
        logic [63:0] o;
        sum = 0;
        if (!dec) begin
            for (int k = 1; k <= r; k++) sum += mask[k-1] ? 1 : 2;
            amt = sum % w;
        end else begin
            for (int k = nr + 2 - r; k <= nr; k++) sum += mask[k-1] ? 1 : 2;
            amt = (w - (sum % w)) % w;
        end
        o = '0;
        for (int b = 0; b < w; b++) begin
            o[(b + amt) % w]     = key[b];
            o[w + (b + amt) % w] = key[w + b];
        end
        return o;
    endfunction

    function automatic logic [63:0] m16(input logic [55:0] key, input logic dec, input int r);
        return model({8'h0, key}, dec, r, 28, 16, 32'h8103);
    endfunction

    task automatic run_sched(input logic [55:0] key, input logic dec,
                             input int stall_at, input int poke_at, input int abort_at,
                             input int probe, input logic [55:0] pcd, input logic [47:0] psk);
        start = 1; key_in = key; decrypt = dec; sub_ready = 1; abort = 0;
        step();
        start = 0; key_in = ~key; decrypt = ~dec;
        for (int r = 1; r <= 16; r++) begin
            chk("round", round, r);
            chk("busy_valid", {busy, sub_valid}, 2'b11);
            chk("cd", sub_cd, m16(key, dec, r));
            chk("done_low", done, 0);
            if (r == probe) begin
                chk("vec_cd", sub_cd, pcd);
`ifdef DES_KS_PC2_EN
                if (psk != 0) chk("vec_subkey", subkey, psk);
`endif
            end
            if (r == stall_at) begin
                sub_ready = 0;
                repeat (5) begin
                    step();
                    chk("stall_round", round, r);
                    chk("stall_cd", sub_cd, m16(key, dec, r));
                    chk("stall_valid", sub_valid, 1);
                end
                sub_ready = 1;
            end
            if (r == poke_at) begin
                start = 1; key_in = key ^ 56'h0F0F_0F0F_0F0F_0F;
            end
            if (r == abort_at) begin
                abort = 1;
                step();
                abort = 0; start = 0;
                chk("abort_round", round, 0);
                chk("abort_valid", {busy, sub_valid}, 2'b00);
                chk("abort_done", done, 0);
                step();
                chk("abort_no_done", done, 0);
                return;
            end
            step();
            start = 0;
        end
        chk("done_pulse", done, 1);
        chk("end_idle", {busy, sub_valid, round}, 0);
        step();
        chk("done_once", done, 0);
    endtask

    typedef struct {
        logic [55:0] key;
        logic        dec;
        int          rnd;
        logic [55:0] cd;
        logic [47:0] sk;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{56'hF0CCAAF556678F, 1'b0, 1,  56'hE19955FAACCF1E, 48'h1B02EFFC7072};
        vecs[1] = '{56'hF0CCAAF556678F, 1'b0, 16, 56'hF0CCAAF556678F, 48'h0};
        vecs[2] = '{56'hF0CCAAF556678F, 1'b1, 1,  56'hF0CCAAF556678F, 48'hCB3D8B0E17F5};
        vecs[3] = '{56'hF0CCAAF556678F, 1'b1, 16, 56'hE19955FAACCF1E, 48'h0};

        rst_n = 1; start = 0; decrypt = 0; abort = 0; sub_ready = 0; key_in = '0;
        m_start = 0; m_decrypt = 0; m_abort = 0; m_ready = 1; m_key = '0;
        #2 rst_n = 0;
        #1;
        chk("rst_outputs", {busy, sub_valid, done, round}, 0);
        chk("rst_cd", sub_cd, 0);
        step(); step();
        rst_n = 1;
        step();

        for (int i = 0; i < 4; i++)
            run_sched(vecs[i].key, vecs[i].dec, 0, 0, 0, vecs[i].rnd, vecs[i].cd, vecs[i].sk);

        for (int i = 0; i < 6; i++)
            run_sched({$urandom, $urandom}, 1'($urandom_range(1)), 0, 0, 0, 0, '0, '0);

        run_sched(56'hF0CCAAF556678F, 1'b0, 3, 0, 0, 0, '0, '0);
        run_sched(56'h123456789ABCDE, 1'b0, 0, 7, 0, 0, '0, '0);
        run_sched(56'h123456789ABCDE, 1'b1, 0, 0, 9, 0, '0, '0);
        run_sched(56'hF0CCAAF556678F, 1'b0, 0, 0, 0, 16, 56'hF0CCAAF556678F, '0);

        // abort in IDLE blocks start
        start = 1; abort = 1; key_in = 56'hABCDEF01234567;
        step();
        start = 0; abort = 0;
        chk("idle_abort_blocks", {busy, round}, 0);

        // async reset at round 5
        start = 1; decrypt = 0; key_in = 56'h0F1E2D3C4B5A69; sub_ready = 1;
        step();
        start = 0;
        repeat (4) step();
        chk("pre_rst_round", round, 5);
        #2 rst_n = 0;
        #1;
        chk("async_rst", {busy, sub_valid, done, round}, 0);
        chk("async_rst_cd", sub_cd, 0);
        step();
        rst_n = 1;
        step();
        chk("post_rst_no_done", {done, busy}, 0);

`ifndef DES_KS_PC2_EN
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] k;
                k = 16'($urandom);
                m_key = k; m_decrypt = 1'(d); m_start = 1;
                step();
                m_start = 0;
                for (int r = 1; r <= 4; r++) begin
                    chk("mini_round", m_round, r);
                    chk("mini_cd", m_cd, model({48'h0, k}, 1'(d), r, 8, 4, 32'h1));
                    step();
                end
                chk("mini_done", {m_done, m_busy}, 2'b10);
                step();
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES/3DES round-key generator, generalised from the fixed 28-bit single-step rotator.
- Takes the post-PC-1 C||D key and walks all NR rounds, one per handshake.
- Rotates each half left for encryption or right for decryption, using a parametrised shift schedule.
- Sits between key load logic and the Feistel round datapath. The round core pulls one round key per accepted transfer.

Parameters:
- W, 28, width of each half (C and D); the key register is 2W bits
- NR, 16, number of rounds
- SHIFT1_MASK, 16'h8103, NR-bit mask; bit r-1 set means encrypt round r rotates by 1, clear means rotates by 2

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load key_in and begin a schedule; honoured only in IDLE
- key_in  input  2W  C in [2W-1:W], D in [W-1:0], sampled on accepted start
- decrypt  input  1  sampled with start; 1 = reverse-order schedule
- abort  input  1  synchronous return to IDLE
- busy  output  1  high in RUN
- sub_valid  output  1  round key valid
- sub_ready  input  1  consumer accepts the round key
- sub_cd  output  2W  current round C||D
- round  output  $clog2(NR+1)  current round number, 1..NR; 0 in IDLE
- done  output  1  one-cycle pulse after round NR is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cd=0, round=0, busy=0, sub_valid=0, done=0, mode=0.
- Notation: s(r) = SHIFT1_MASK[r-1] ? 1 : 2.
- Rotations act on C and D independently, each modulo W bits.
- IDLE + start:
  - mode <= decrypt; round <= 1; state <= RUN.
  - Encrypt: cd <= rotl(key_in, s(1)).
  - Decrypt: cd <= key_in (no shift).
- RUN:
  - sub_valid=1, busy=1, sub_cd=cd, combinationally from registers.
  - sub_cd and round must stay stable while sub_ready=0.
- Transfer = sub_valid & sub_ready.
  - On transfer at round i<NR: round <= i+1.
    - Encrypt: cd <= rotl(cd, s(i+1)).
    - Decrypt: cd <= rotr(cd, s(NR+1-i)).
  - On transfer at round NR: state <= IDLE, round <= 0, sub_valid <= 0, done <= 1 for one cycle. cd holds its value.
- Latency: first round key is valid the cycle after start is accepted. With sub_ready held high, one key per cycle; NR keys occupy NR cycles.
- start while in RUN: ignored. No reload and no effect on the sequence.
- start and done in the same cycle: done is already registered; start is accepted because state is IDLE.
- abort: takes priority over transfer and start.
  - RUN -> IDLE next cycle; sub_valid=0, round=0, no done pulse.
  - In IDLE, abort also blocks start.
- rst_n asserted mid-schedule: immediate clear to reset values; no done pulse.
- With the default mask, total rotation over a full schedule is 28. Encrypt round NR therefore ends at cd == key_in.

Optional Feature:
- Macro: DES_KS_PC2_EN
- Defined:
  - Adds output subkey [47:0] = PC-2 (FIPS 46-3) of sub_cd, combinational, qualified by sub_valid.
  - Forces W=28; elaboration fails on any other W.
  - subkey reads 0 in IDLE.
- Undefined: no subkey port; W is free.

Test Plan:
- Reset, then drive start with key_in=56'hF0CCAAF556678F, decrypt=0, sub_ready=1:
  - Round 1: sub_cd=56'hE19955FAACCF1E.
  - Round 16: sub_cd=56'hF0CCAAF556678F.
  - done pulses the cycle after round 16; with PC2, round 1 subkey=48'h1B02EFFC7072.
- Same key, decrypt=1:
  - Round 1: sub_cd=56'hF0CCAAF556678F (PC2: 48'hCB3D8B0E17F5).
  - Round 16: sub_cd=56'hE19955FAACCF1E.
  - The 16 keys equal the encrypt run reversed.
- Encrypt run with sub_ready low for 5 cycles at round 3:
  - sub_cd and round=3 hold.
  - Exactly 16 transfers; done exactly once.
- start pulsed at round 7 with a different key_in: sequence unchanged and completes normally.
- abort asserted at round 9 together with sub_ready=1:
  - Next cycle: IDLE, round=0, sub_valid=0, done=0.
  - A following start runs a fresh 16-round schedule.
- rst_n dropped asynchronously at round 5: outputs clear immediately, without waiting for clk; W=8, NR=4, SHIFT1_MASK=4'b0001 config also passes rotation checks.
